// File: rtl/resp_compactor_if.sv
// Response-pair handshake between the circuit-under-test harness and the compactor.
interface resp_compactor_if #(
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] resp_a;
  logic [OUT_W-1:0] resp_b;

  modport master (output in_valid, output resp_a, output resp_b, input in_ready);
  modport slave  (input in_valid, input resp_a, input resp_b, output in_ready);
endinterface

// File: rtl/resp_compactor.sv
// Compacts golden/simplified response streams into MISR signatures, counts
// differing vectors, records the first failure and reports a pass/fail verdict.
module resp_compactor #(
  parameter int               OUT_W = 8,
  parameter int               CNT_W = 16,
  parameter logic [OUT_W-1:0] POLY  = 8'hB8,
  parameter logic [OUT_W-1:0] SEED  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vec,
  resp_compactor_if.slave      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CNT_W-1:0]     first_fail_idx,
  output logic [OUT_W-1:0]     first_fail_xor,
  output logic [OUT_W-1:0]     sig_a,
  output logic [OUT_W-1:0]     sig_b
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic             fail_seen_q, fail_seen_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic [OUT_W-1:0] first_fail_xor_q, first_fail_xor_d;
  logic [OUT_W-1:0] sig_a_q, sig_a_d;
  logic [OUT_W-1:0] sig_b_q, sig_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             in_ready_q, in_ready_d;

  logic             xfer;
  logic             differ;

  // Galois MISR step: shift right, fold in POLY when the LSB falls out, absorb r.
  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] r);
    return (s >> 1) ^ (s[0] ? POLY : '0) ^ r;
  endfunction

  always_comb begin
    state_d          = state_q;
    num_vec_d        = num_vec_q;
    vec_idx_d        = vec_idx_q;
    fail_seen_d      = fail_seen_q;
    mismatch_cnt_d   = mismatch_cnt_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_xor_d = first_fail_xor_q;
    sig_a_d          = sig_a_q;
    sig_b_d          = sig_b_q;

    xfer   = (state_q == S_RUN) && bus.in_valid;
    differ = (bus.resp_a != bus.resp_b);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_vec_d        = num_vec;
          vec_idx_d        = '0;
          fail_seen_d      = 1'b0;
          mismatch_cnt_d   = '0;
          first_fail_idx_d = '0;
          first_fail_xor_d = '0;
          sig_a_d          = SEED;
          sig_b_d          = SEED;
          state_d          = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          sig_a_d   = misr_step(sig_a_q, bus.resp_a);
          sig_b_d   = misr_step(sig_b_q, bus.resp_b);
          vec_idx_d = vec_idx_q + 1'b1;
          if (differ) begin
            if (mismatch_cnt_q != '1) begin
              mismatch_cnt_d = mismatch_cnt_q + 1'b1;
            end
            if (!fail_seen_q) begin
              first_fail_idx_d = vec_idx_q;
              first_fail_xor_d = bus.resp_a ^ bus.resp_b;
              fail_seen_d      = 1'b1;
            end
          end
          if (vec_idx_q == num_vec_q - 1'b1) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are derived from next-state values so they land registered.
    busy_d     = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    in_ready_d = (state_d == S_RUN);
    pass_d     = (state_d == S_DONE) && (mismatch_cnt_d == '0) && (sig_a_d == sig_b_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      num_vec_q        <= '0;
      vec_idx_q        <= '0;
      fail_seen_q      <= 1'b0;
      mismatch_cnt_q   <= '0;
      first_fail_idx_q <= '0;
      first_fail_xor_q <= '0;
      sig_a_q          <= SEED;
      sig_b_q          <= SEED;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      in_ready_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      num_vec_q        <= num_vec_d;
      vec_idx_q        <= vec_idx_d;
      fail_seen_q      <= fail_seen_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_xor_q <= first_fail_xor_d;
      sig_a_q          <= sig_a_d;
      sig_b_q          <= sig_b_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      in_ready_q       <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign mismatch_cnt    = mismatch_cnt_q;
  assign first_fail_idx  = first_fail_idx_q;
  assign first_fail_xor  = first_fail_xor_q;
  assign sig_a           = sig_a_q;
  assign sig_b           = sig_b_q;

endmodule

// File: tb/tb_resp_compactor.sv
// Self-checking bench for resp_compactor: directed scenarios plus randomized runs
// checked against a queue-based reference model of the signature/mismatch rules.
module tb_resp_compactor;

  localparam logic [7:0] REF_POLY = 8'hB8;
  localparam logic [7:0] REF_SEED = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic        busy, done, pass;
  logic [15:0] mismatch_cnt, first_fail_idx;
  logic [7:0]  first_fail_xor, sig_a, sig_b;

  int checks = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         validPat[$];
  int         lastCycles;

  logic [7:0]  expSigA, expSigB, expXor;
  logic [15:0] expMis, expIdx;
  logic        expPass;

  resp_compactor_if #(.OUT_W(8)) bus ();

  resp_compactor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vec        (num_vec),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_xor (first_fail_xor),
    .sig_a          (sig_a),
    .sig_b          (sig_b)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signature is the MISR recurrence folded over the whole vector list.
  task automatic computeExpected();
    int mis;
    bit seen;
    expSigA = REF_SEED;
    expSigB = REF_SEED;
    mis = 0;
    seen = 0;
    expIdx = '0;
    expXor = '0;
    foreach (qa[i]) begin
      expSigA = (expSigA >> 1) ^ ((expSigA % 2 == 1) ? REF_POLY : 8'h00) ^ qa[i];
      expSigB = (expSigB >> 1) ^ ((expSigB % 2 == 1) ? REF_POLY : 8'h00) ^ qb[i];
      if (qa[i] != qb[i]) begin
        mis++;
        if (!seen) begin
          seen = 1;
          expIdx = 16'(i);
          expXor = qa[i] ^ qb[i];
        end
      end
    end
    expMis = (mis > 65535) ? 16'hFFFF : 16'(mis);
    expPass = (mis == 0) && (expSigA == expSigB);
  endtask

  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " pass"}, pass, 0);
    checkOutput({tag, " in_ready"}, bus.in_ready, 0);
    checkOutput({tag, " sig_a"}, sig_a, REF_SEED);
    checkOutput({tag, " sig_b"}, sig_b, REF_SEED);
    checkOutput({tag, " mismatch_cnt"}, mismatch_cnt, 0);
    checkOutput({tag, " first_fail_idx"}, first_fail_idx, 0);
    checkOutput({tag, " first_fail_xor"}, first_fail_xor, 0);
  endtask

  task automatic startRun(input int n, input string tag);
    start = 1'b1;
    num_vec = 16'(n);
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.resp_a = 8'($urandom);
    bus.resp_b = 8'($urandom);
    tick();
    start = 1'b0;
    num_vec = 16'($urandom);
    checkOutput({tag, " busy after start"}, busy, (n != 0));
    checkOutput({tag, " done after start"}, done, (n == 0));
  endtask

  // Feeds qa/qb through the handshake; valid comes from validPat if set, else random.
  task automatic applyStimulus(input string tag, input bit injectStart);
    int  n;
    int  k;
    int  cycles;
    bit  v;
    bit  acc;
    logic [7:0] holdA, holdB;
    n = qa.size();
    k = 0;
    cycles = 0;
    while (k < n && cycles < 2000) begin
      if (validPat.size() > 0) v = (validPat[cycles % validPat.size()] != 0);
      else v = ($urandom_range(0, 2) != 0);
      bus.in_valid = v;
      bus.resp_a = qa[k];
      bus.resp_b = qb[k];
      if (injectStart) begin
        start = ($urandom_range(0, 5) == 0);
        num_vec = 16'($urandom_range(0, 3));
      end
      acc = v && (bus.in_ready === 1'b1);
      tick();
      cycles++;
      if (acc) k++;
    end
    start = 1'b0;
    lastCycles = cycles;
    if (k < n) begin
      checkOutput({tag, " transfer timeout"}, k, n);
    end else begin
      checkOutput({tag, " done latency"}, done, 1);
      checkOutput({tag, " in_ready after last"}, bus.in_ready, 0);
    end
    holdA = sig_a;
    holdB = sig_b;
    bus.in_valid = 1'b1;
    repeat (2) begin
      bus.resp_a = 8'($urandom);
      bus.resp_b = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    checkOutput({tag, " trailing sig_a hold"}, sig_a, holdA);
    checkOutput({tag, " trailing sig_b hold"}, sig_b, holdB);
  endtask

  task automatic checkResults(input string tag);
    computeExpected();
    checkOutput({tag, " sig_a"}, sig_a, expSigA);
    checkOutput({tag, " sig_b"}, sig_b, expSigB);
    checkOutput({tag, " mismatch_cnt"}, mismatch_cnt, expMis);
    checkOutput({tag, " first_fail_idx"}, first_fail_idx, expIdx);
    checkOutput({tag, " first_fail_xor"}, first_fail_xor, expXor);
    checkOutput({tag, " pass"}, pass, expPass);
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int expCycles;
    int ones;
    bus.in_valid = 1'b0;
    bus.resp_a = '0;
    bus.resp_b = '0;

    doReset(2);
    checkResetState("reset");

    qa = '{8'h00};
    qb = '{8'h00};
    startRun(1, "single00");
    applyStimulus("single00", 0);
    checkResults("single00");
    checkOutput("single00 sig_a const", sig_a, 8'hC7);

    qa = '{8'h01};
    qb = '{8'h01};
    startRun(1, "single01");
    applyStimulus("single01", 0);
    checkResults("single01");
    checkOutput("single01 sig_a const", sig_a, 8'hC6);

    qa = {8'($urandom), 8'($urandom), 8'h5A, 8'($urandom)};
    qb = {qa[0], qa[1], 8'h58, qa[3]};
    validPat = '{1};
    startRun(4, "mis4");
    applyStimulus("mis4", 0);
    checkResults("mis4");
    checkOutput("mis4 xfer cycles", lastCycles, 4);
    checkOutput("mis4 idx const", first_fail_idx, 2);
    checkOutput("mis4 xor const", first_fail_xor, 8'h02);

    qa = {8'($urandom), 8'($urandom), 8'($urandom)};
    qb = qa;
    validPat = '{1, 0, 0, 1, 0, 1, 1, 1};
    expCycles = 0;
    ones = 0;
    foreach (validPat[i]) begin
      if (ones < 3) begin
        expCycles = i + 1;
        if (validPat[i] != 0) ones++;
      end
    end
    startRun(3, "bp");
    applyStimulus("bp", 0);
    checkResults("bp");
    checkOutput("bp xfer cycles", lastCycles, expCycles);
    validPat.delete();

    qa.delete();
    qb.delete();
    startRun(0, "zero");
    checkResults("zero");
    bus.in_valid = 1'b1;
    repeat (3) begin
      checkOutput("zero in_ready", bus.in_ready, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    checkResults("zero hold");

    startRun(5, "midrst");
    bus.in_valid = 1'b1;
    bus.resp_a = 8'h11;
    bus.resp_b = 8'h22;
    tick();
    tick();
    bus.in_valid = 1'b0;
    checkOutput("midrst mismatches seen", mismatch_cnt, 2);
    doReset(2);
    checkResetState("midrst after reset");
    qa = '{8'h3C};
    qb = '{8'h3C};
    startRun(1, "postrst");
    applyStimulus("postrst", 0);
    checkResults("postrst");
    checkOutput("postrst pass const", pass, 1);

    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(1, 12);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] a;
        a = 8'($urandom);
        qa.push_back(a);
        if ($urandom_range(0, 2) == 0) qb.push_back(a ^ 8'($urandom_range(1, 255)));
        else qb.push_back(a);
      end
      startRun(n, "rand");
      applyStimulus("rand", 1);
      checkResults("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/resp_compactor.md
Name: resp_compactor

Overview:
- Downstream stage of the combinational benchmark circuits used in equivalence runs.
- Consumes the 8-bit output vectors of two circuit versions (golden and simplified) that are driven by the same input pattern, one pattern per handshake.
- Compacts each response stream into a MISR signature, counts vectors where the two responses differ, and records the first failing vector.
- Reports a pass/fail verdict after a programmed number of vectors.

Parameters:
- OUT_W, 8, width of each response vector.
- CNT_W, 16, width of vector count, index and mismatch counters.
- POLY, 8'hB8, Galois MISR feedback mask (OUT_W bits).
- SEED, 8'hFF, MISR initial value (OUT_W bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- num_vec  in  CNT_W  number of vectors in the run; sampled when start is accepted.
- in_valid  in  1  response pair valid.
- in_ready  out  1  block accepts a response pair.
- resp_a  in  OUT_W  golden circuit outputs.
- resp_b  in  OUT_W  simplified circuit outputs.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  verdict; meaningful only while done=1.
- mismatch_cnt  out  CNT_W  count of accepted vectors with resp_a != resp_b.
- first_fail_idx  out  CNT_W  index of the first mismatching vector.
- first_fail_xor  out  OUT_W  resp_a ^ resp_b of the first mismatching vector.
- sig_a  out  OUT_W  MISR signature of resp_a.
- sig_b  out  OUT_W  MISR signature of resp_b.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values:
  - State is IDLE.
  - busy=0, done=0, pass=0, in_ready=0.
  - mismatch_cnt=0, first_fail_idx=0, first_fail_xor=0.
  - sig_a=sig_b=SEED.
  - Internal vec_idx=0, fail_seen=0.
- Reset asserted mid-run aborts the run with no residual state.
- All outputs are registered. in_ready is a pure function of state (high only in RUN).
- FSM: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - latch num_vec;
  - clear mismatch_cnt, first_fail_idx, first_fail_xor, vec_idx and fail_seen;
  - load sig_a=sig_b=SEED.
  - Next state is RUN, or DONE if num_vec==0.
  - A start that enters DONE directly yields pass=1 with signatures equal to SEED.
- RUN:
  - A transfer occurs on the cycle where in_valid & in_ready.
  - No transfer means no state change; in_valid may drop or stay low arbitrarily.
  - start is ignored in RUN.
- On each transfer, with the MISR step defined as m(s,r) = (s>>1) ^ (s[0] ? POLY : 0) ^ r:
  - sig_a <= m(sig_a, resp_a); sig_b <= m(sig_b, resp_b).
  - If resp_a != resp_b: mismatch_cnt increments, saturating at all-ones.
  - If resp_a != resp_b and fail_seen=0: first_fail_idx <= vec_idx, first_fail_xor <= resp_a^resp_b, fail_seen <= 1.
  - vec_idx increments.
- Last transfer (vec_idx == latched num_vec - 1):
  - Next state is DONE, so in_ready=0 in the following cycle.
  - in_valid still high after the last transfer must cause no further update.
- DONE:
  - done=1, busy=0.
  - pass = (mismatch_cnt==0) && (sig_a==sig_b), computed from the registered values and stable until the next start or reset.
  - Results hold until the next start.
- Latency: done rises exactly one cycle after the final transfer.
- Simultaneous start and in_valid in IDLE or DONE: start wins and no transfer occurs (in_ready=0 in those states).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> busy=0, done=0, pass=0, in_ready=0, sig_a=sig_b=0xFF, mismatch_cnt=0.
- start with num_vec=1, then one transfer with resp_a=resp_b=0x00 -> next cycle sig_a=sig_b=0xC7, done=1, pass=1, mismatch_cnt=0. Repeating with resp_a=resp_b=0x01 -> sig=0xC6.
- num_vec=4; vectors 0, 1 and 3 identical; vector 2 has resp_a=0x5A, resp_b=0x58 -> mismatch_cnt=1, first_fail_idx=2, first_fail_xor=0x02, pass=0, done=1 one cycle after the 4th transfer.
- Backpressure: num_vec=3 with in_valid pattern 1,0,0,1,0,1,1,1 -> exactly 3 transfers counted, done one cycle after the 6th cycle; the trailing in_valid=1 cycles cause no signature change.
- num_vec=0 start -> done=1 on the next cycle, pass=1, sigs=0xFF, in_ready never asserted.
- Reset mid-run after 2 of 5 transfers -> all outputs return to reset values. A new start with num_vec=1 and equal responses then completes with pass=1.
